// File: rtl/ram_dp_param_pkg.sv
// Shared types, constants and helpers for the parametrised dual-port RAM
// and its post-reset clear sequencer.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int nbytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/ram_dp_param_if.sv
// Write/read port bundle of ram_dp_param; the RAM uses the slave view.
interface ram_dp_param_if #(
  parameter int DATA_WIDTH = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  localparam int NB = ram_pkg::nbytes(DATA_WIDTH, BYTE_WIDTH);

  logic                  wr_enb;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_be;
  logic                  rd_enb;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  init_done;
  logic                  access_drop;

  modport master (
    output wr_enb, wr_addr, wr_data, wr_be, rd_enb, rd_addr,
    input  rd_data, rd_valid, init_done, access_drop
  );

  modport slave (
    input  wr_enb, wr_addr, wr_data, wr_be, rd_enb, rd_addr,
    output rd_data, rd_valid, init_done, access_drop
  );

endinterface

// File: rtl/ram_dp_param_clear_ctrl.sv
// Post-reset clear sequencer: walks every address once writing zero, then
// holds READY until the next reset.
//   state | meaning
//   CLEAR | zeroing ram[cnt_q], one word per cycle; user accesses refused
//   READY | memory cleared, normal read/write accepted
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LastAddr) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // No clearing while reset is held; the sweep starts on the first free cycle.
  always_comb begin
    clr_we    = (state_q == CLEAR) && !rst;
    clr_addr  = cnt_q;
    init_done = (state_q == READY);
  end

endmodule

// File: rtl/ram_dp_param.sv
// Simple dual-port synchronous RAM with byte-lane writes, 1- or 2-cycle read
// latency, selectable read-during-write result and a sequenced post-reset clear.
module ram_dp_param
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2 ** ADDR_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = RDW_OLD
) (
  input  logic          clk,
  input  logic          rst,
  ram_dp_param_if.slave bus
);

  localparam int                  NB     = nbytes(DATA_WIDTH, BYTE_WIDTH);
  localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_chk_bw
    $error("ram_dp_param: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_chk_lat
    $error("ram_dp_param: RD_LATENCY must be 1 or 2");
  end
  if (DEPTH < 1 || DEPTH > 2 ** ADDR_WIDTH) begin : g_chk_depth
    $error("ram_dp_param: DEPTH must be in 1..2**ADDR_WIDTH");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_chk_rdw
    $error("ram_dp_param: RDW_MODE must be 0 or 1");
  end

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  init_done;

  ram_clear_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done)
  );

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept, wr_in_range, rd_in_range, wr_go, rd_go;
  logic [DATA_WIDTH-1:0] wr_old, wr_merged, rd_word;

  always_comb begin
    accept      = init_done && !rst;
    wr_in_range = {1'b0, bus.wr_addr} < DepthW;
    rd_in_range = {1'b0, bus.rd_addr} < DepthW;
    wr_go       = accept && bus.wr_enb && wr_in_range;
    rd_go       = accept && bus.rd_enb;
    wr_old      = wr_in_range ? mem_q[bus.wr_addr] : '0;
    wr_merged   = wr_old;
    for (int k = 0; k < NB; k++) begin
      if (bus.wr_be[k]) wr_merged[k*BYTE_WIDTH +: BYTE_WIDTH] = bus.wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
    // Out-of-range reads still complete, returning zero.
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[bus.rd_addr];
      if (RDW_MODE == RDW_NEW && wr_go && bus.wr_addr == bus.rd_addr) rd_word = wr_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) mem_q[clr_addr] <= '0;
    else if (wr_go) mem_q[bus.wr_addr] <= wr_merged;
  end

  logic                  drop_q, s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      drop_q     <= !init_done && (bus.wr_enb || bus.rd_enb);
      s1_valid_q <= rd_go;
      if (rd_go) s1_data_q <= rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s2_data_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end
    assign bus.rd_valid = s2_valid_q;
    assign bus.rd_data  = s2_data_q;
  end else begin : g_lat1
    assign bus.rd_valid = s1_valid_q;
    assign bus.rd_data  = s1_data_q;
  end

  assign bus.init_done   = init_done;
  assign bus.access_drop = drop_q;

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: four configurations share one stimulus set; sel
// routes requests and outputs to the configuration under test.
module tb_ram_dp_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  sel;
  logic        wr_enb, rd_enb;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat   = 1;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] data;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  ram_dp_param_if bus [4] ();

  logic [3:0]  rdv_v, idn_v, drp_v;
  logic [15:0] rdd_v [4];
  logic        rd_valid_s, init_done_s, access_drop_s;
  logic [15:0] rd_data_s;

  for (genvar g = 0; g < 4; g++) begin : g_bus
    assign bus[g].wr_enb  = wr_enb && (sel == 2'(g));
    assign bus[g].rd_enb  = rd_enb && (sel == 2'(g));
    assign bus[g].wr_addr = wr_addr;
    assign bus[g].wr_data = wr_data;
    assign bus[g].wr_be   = wr_be;
    assign bus[g].rd_addr = rd_addr;
    assign rdv_v[g] = bus[g].rd_valid;
    assign idn_v[g] = bus[g].init_done;
    assign drp_v[g] = bus[g].access_drop;
    assign rdd_v[g] = bus[g].rd_data;
  end

  assign rd_valid_s    = rdv_v[sel];
  assign init_done_s   = idn_v[sel];
  assign access_drop_s = drp_v[sel];
  assign rd_data_s     = rdd_v[sel];

  // 0: defaults, 1: write-through, 2: two-cycle read, 3: DEPTH=12
  ram_dp_param #(.RDW_MODE(0))   dut_a (.clk(clk), .rst(rst), .bus(bus[0]));
  ram_dp_param #(.RDW_MODE(1))   dut_b (.clk(clk), .rst(rst), .bus(bus[1]));
  ram_dp_param #(.RD_LATENCY(2)) dut_c (.clk(clk), .rst(rst), .bus(bus[2]));
  ram_dp_param #(.DEPTH(12))     dut_d (.clk(clk), .rst(rst), .bus(bus[3]));

  task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input logic re, input logic [3:0] ra,
                       input logic exp_rd, input logic [15:0] rexp, input string tag);
    wr_enb = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_enb = re; rd_addr = ra;
    if (re && exp_rd) sb.push_back('{cyc + lat, rexp, tag});
    @(posedge clk); #1;
    wr_enb = 1'b0; rd_enb = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    drive(1'b1, a, d, be, 1'b0, 4'd0, 1'b0, 16'h0, "");
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp_d, input string tag);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, a, 1'b1, exp_d, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 1'b0, 16'h0, "");
  endtask

  task automatic test_reset();
    sel = 2'd0; lat = 1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (rd_data_s !== 16'h0) begin fails++; $display("FAIL reset_rd_data: got %h, required 0000", rd_data_s); end
    tests++; if (rd_valid_s !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b, required 0", rd_valid_s); end
    tests++; if (init_done_s !== 1'b0) begin fails++; $display("FAIL reset_init_done: got %b, required 0", init_done_s); end
    tests++; if (access_drop_s !== 1'b0) begin fails++; $display("FAIL reset_access_drop: got %b, required 0", access_drop_s); end
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 1) drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd0, 1'b0, 16'h0, "");
      else idle(1);
      tests++;
      if (init_done_s !== (k == 16)) begin
        fails++; $display("FAIL clear_init_done: got %b after clear edge %0d, required %b", init_done_s, k, (k == 16));
      end
      if (k <= 2) begin
        tests++;
        if (access_drop_s !== (k == 1)) begin
          fails++; $display("FAIL clear_access_drop: got %b after clear edge %0d, required %b", access_drop_s, k, (k == 1));
        end
      end
    end
    for (int a = 0; a < 16; a++) rd(4'(a), 16'h0000, "clear_read_zero");
    idle(3);
  endtask

  task automatic test_write_read();
    sel = 2'd0; lat = 1;
    wr(4'd3, 16'hABCD, 2'b11);
    rd(4'd3, 16'hABCD, "wr_rd_addr3");
    wr(4'd15, 16'h0F0F, 2'b11);
    rd(4'd15, 16'h0F0F, "wr_rd_addr15");
    rd(4'd14, 16'h0000, "rd_neighbour14");
    idle(2);
  endtask

  task automatic test_byte_enable();
    sel = 2'd0; lat = 1;
    wr(4'd3, 16'h1234, 2'b01);
    rd(4'd3, 16'hAB34, "be_low_lane");
    wr(4'd3, 16'hFFFF, 2'b00);
    rd(4'd3, 16'hAB34, "be_none");
    wr(4'd3, 16'h5600, 2'b10);
    rd(4'd3, 16'h5634, "be_high_lane");
    idle(2);
  endtask

  task automatic test_rdw(input logic [1:0] s, input int mode);
    sel = s; lat = 1;
    drive(1'b1, 4'd5, 16'h5555, 2'b11, 1'b1, 4'd5, 1'b1, (mode == 1) ? 16'h5555 : 16'h0000, "rdw_full_word");
    rd(4'd5, 16'h5555, "rdw_after_full");
    drive(1'b1, 4'd6, 16'hAAAA, 2'b10, 1'b1, 4'd6, 1'b1, (mode == 1) ? 16'hAA00 : 16'h0000, "rdw_one_lane");
    rd(4'd6, 16'hAA00, "rdw_after_lane");
    drive(1'b1, 4'd7, 16'h7777, 2'b11, 1'b1, 4'd5, 1'b1, 16'h5555, "rdw_diff_addr");
    idle(2);
  endtask

  task automatic test_mid_clear();
    sel = 2'd0; lat = 1;
    for (int a = 0; a < 16; a++) wr(4'(a), 16'hFFFF, 2'b11);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    idle(6);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 10) wr(4'd2, 16'h2222, 2'b11);
      else idle(1);
      tests++;
      if (init_done_s !== (k == 16)) begin
        fails++; $display("FAIL reclear_init_done: got %b after clear edge %0d, required %b", init_done_s, k, (k == 16));
      end
      if (k == 10 || k == 11) begin
        tests++;
        if (access_drop_s !== (k == 10)) begin
          fails++; $display("FAIL reclear_access_drop: got %b after clear edge %0d, required %b", access_drop_s, k, (k == 10));
        end
      end
    end
    for (int a = 0; a < 16; a++) rd(4'(a), 16'h0000, "reclear_read_zero");
    idle(2);
  endtask

  task automatic test_latency2();
    logic [15:0] w;
    sel = 2'd2; lat = 2;
    for (int a = 0; a < 16; a++) begin
      w = 16'(a) * 16'h0101;
      wr(4'(a), w, 2'b11);
    end
    for (int a = 0; a < 16; a++) begin
      w = 16'(a) * 16'h0101;
      rd(4'(a), w, "lat2_stream");
    end
    idle(3);
  endtask

  task automatic test_out_of_range();
    sel = 2'd3; lat = 1;
    wr(4'd13, 16'h7777, 2'b11);
    wr(4'd11, 16'h1111, 2'b11);
    wr(4'd12, 16'hCCCC, 2'b11);
    rd(4'd13, 16'h0000, "oob_read13");
    rd(4'd11, 16'h1111, "last_word11");
    rd(4'd12, 16'h0000, "oob_read12");
    rd(4'd15, 16'h0000, "oob_read15");
    rd(4'd1, 16'h0000, "no_alias1");
    rd(4'd0, 16'h0000, "no_alias0");
    idle(2);
  endtask

  initial begin
    rst = 1'b1; sel = 2'd0;
    wr_enb = 1'b0; rd_enb = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    fork
      forever begin
        @(negedge clk);
        if (rd_valid_s === 1'b1) begin
          tests++;
          if (sb.size() == 0) begin
            fails++; $display("FAIL rd_unexpected: rd_valid=1 rd_data=%h at cycle %0d, required rd_valid=0", rd_data_s, cyc);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.due != cyc || rd_data_s !== mon_e.data) begin
              fails++; $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d", mon_e.tag, rd_data_s, cyc, mon_e.data, mon_e.due);
            end
          end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
          tests++; fails++;
          mon_e = sb.pop_front();
          $display("FAIL %s: no rd_valid at cycle %0d, required %h", mon_e.tag, cyc, mon_e.data);
        end
      end
    join_none
    test_reset();
    test_write_read();
    test_byte_enable();
    test_rdw(2'd0, 0);
    test_rdw(2'd1, 1);
    test_mid_clear();
    test_latency2();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion before 100000 time units");
    $fatal(1);
  end

endmodule
